// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
// Shared types and constants for the two-requester register-file arbiter.
//   NREQ        : number of requesters (fixed at 2)
//   arb_state_e : ownership state (IDLE, LOCK0, LOCK1)
//   req_id_t    : requester index
//   req_onehot  : requester index -> one-hot grant vector
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  function automatic logic [NREQ-1:0] req_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_arbiter_if
// Requester-side bus of regfile_arbiter: per-requester request channel plus
// the shared tagged read-response channel.
//   req_valid/req_ready [NREQ]   : handshake, transfer = valid && ready
//   req_we, req_lock    [NREQ]   : write/read-pair select, keep ownership
//   req_ra1/ra2/wa      [NREQ]   : addresses
//   req_wd              [NREQ]   : write data
//   rsp_valid, rsp_id            : read response strobe and issuing requester
//   rsp_rd1, rsp_rd2             : read data
// Modports: master = requesters, slave = arbiter.
// -----------------------------------------------------------------------------
interface regfile_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32
);

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0]             req_lock;
  logic [NREQ-1:0][RWIDTH-1:0] req_ra1;
  logic [NREQ-1:0][RWIDTH-1:0] req_ra2;
  logic [NREQ-1:0][RWIDTH-1:0] req_wa;
  logic [NREQ-1:0][DWIDTH-1:0] req_wd;

  logic                        rsp_valid;
  req_id_t                     rsp_id;
  logic [DWIDTH-1:0]           rsp_rd1;
  logic [DWIDTH-1:0]           rsp_rd2;

  modport master (
    output req_valid, req_we, req_lock, req_ra1, req_ra2, req_wa, req_wd,
    input  req_ready, rsp_valid, rsp_id, rsp_rd1, rsp_rd2
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_ra1, req_ra2, req_wa, req_wd,
    output req_ready, rsp_valid, rsp_id, rsp_rd1, rsp_rd2
  );

endinterface

// File: rtl/regfile_arb_rr2.sv
// -----------------------------------------------------------------------------
// regfile_arb_rr2
// Two-way round-robin grant. A requester is eligible when valid and not masked
// off; with both eligible the priority pointer decides. After every grant the
// pointer moves to the other requester.
//   clk, rst  : clock, synchronous active-high reset (pointer -> requester 0)
//   valid     : request present per requester
//   mask      : 1 = requester may be granted this cycle
//   grant     : one-hot grant (combinational)
//   gnt_id    : index of the granted requester (meaningful when |grant)
// -----------------------------------------------------------------------------
module regfile_arb_rr2
  import regfile_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant,
  output req_id_t         gnt_id
);

  req_id_t         ptr_q;
  logic [NREQ-1:0] eligible;

  assign eligible = valid & mask;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_id = 1'b0;
    grant  = '0;
    unique case (eligible)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr_q;
      default: gnt_id = 1'b0;
    endcase
    if (eligible != '0) grant = req_onehot(gnt_id);
  end

  // NOTE: clocked state uses non-blocking assignments so all registers see
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst)           ptr_q <= 1'b0;
    else if (|grant)   ptr_q <= ~gnt_id;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
// Serialises read-pair and write requests from two masters onto the single
// access slot of a register file with registered read data. Round-robin
// fairness, optional ownership lock for read-modify-write, tagged response
// one cycle after a read is issued.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : requester channels and read response
//   rf_ra1/ra2/wa   : addresses to the register file
//   rf_wd, rf_we    : write data / enable to the register file
//   rf_rd1, rf_rd2  : registered read data from the register file
// Build option: REGFILE_ARB_R0_ZERO_EN makes register 0 read as zero and
// silently drops writes to it (the write is still accepted).
// -----------------------------------------------------------------------------
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arbiter_if.slave  bus,
  output logic [RWIDTH-1:0] rf_ra1,
  output logic [RWIDTH-1:0] rf_ra2,
  output logic [RWIDTH-1:0] rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  output logic              rf_we,
  input  logic [DWIDTH-1:0] rf_rd1,
  input  logic [DWIDTH-1:0] rf_rd2
);

`ifdef REGFILE_ARB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] grant;
  req_id_t         gnt_id;
  logic            xfer;
  logic            wr_r0;

  logic            rsp_valid_q;
  req_id_t         rsp_id_q;
  logic            rsp_z1_q, rsp_z2_q;

  // A locked state admits only its owner; nothing is granted while in reset
  // so no write can slip into the regfile and no response is lost.
  always_comb begin
    mask = 2'b11;
    unique case (state_q)
      LOCK0:   mask = 2'b01;
      LOCK1:   mask = 2'b10;
      default: mask = 2'b11;
    endcase
    if (rst) mask = 2'b00;
  end

  regfile_arb_rr2 u_rr2 (
    .clk    (clk),
    .rst    (rst),
    .valid  (bus.req_valid),
    .mask   (mask),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign xfer          = |grant;
  assign bus.req_ready = grant;

  // Ownership: a transfer with lock held moves to (or stays in) the owner's
  // lock state; a transfer without lock returns to IDLE. No transfer: hold.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      if (bus.req_lock[gnt_id]) state_d = gnt_id ? LOCK1 : LOCK0;
      else                      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign wr_r0 = R0_ZERO && (bus.req_wa[gnt_id] == '0);

  // Granted request steers the regfile port; idle cycles drive zeros.
  always_comb begin
    rf_ra1 = '0;
    rf_ra2 = '0;
    rf_wa  = '0;
    rf_wd  = '0;
    rf_we  = 1'b0;
    if (xfer) begin
      rf_ra1 = bus.req_ra1[gnt_id];
      rf_ra2 = bus.req_ra2[gnt_id];
      rf_wa  = bus.req_wa[gnt_id];
      rf_wd  = bus.req_wd[gnt_id];
      rf_we  = bus.req_we[gnt_id] & ~wr_r0;
    end
  end

  // Response tag tracks the regfile's one-cycle read register. The zero flags
  // remember whether each read address was register 0 so its data can be
  // masked when the response is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_z1_q    <= 1'b0;
      rsp_z2_q    <= 1'b0;
    end else begin
      rsp_valid_q <= xfer && !bus.req_we[gnt_id];
      if (xfer) begin
        rsp_id_q <= gnt_id;
        rsp_z1_q <= R0_ZERO && (rf_ra1 == '0);
        rsp_z2_q <= R0_ZERO && (rf_ra2 == '0);
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rd1   = (rsp_valid_q && !rsp_z1_q) ? rf_rd1 : '0;
  assign bus.rsp_rd2   = (rsp_valid_q && !rsp_z2_q) ? rf_rd2 : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
// Directed bench for regfile_arbiter with a behavioural register file
// (registered read data). Expected responses are queued when reads are issued
// and a negedge monitor compares them against the response channel.
// Honours REGFILE_ARB_R0_ZERO_EN in its expectations.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;
  import regfile_arb_pkg::*;

  localparam int RW = 6;
  localparam int DW = 32;

`ifdef REGFILE_ARB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mdl_clr;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.RWIDTH(RW), .DWIDTH(DW)) bus ();

  logic [RW-1:0] rf_ra1, rf_ra2, rf_wa;
  logic [DW-1:0] rf_wd, rf_rd1, rf_rd2;
  logic          rf_we;

  regfile_arbiter #(.RWIDTH(RW), .DWIDTH(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rf_ra1 (rf_ra1),
    .rf_ra2 (rf_ra2),
    .rf_wa  (rf_wa),
    .rf_wd  (rf_wd),
    .rf_we  (rf_we),
    .rf_rd1 (rf_rd1),
    .rf_rd2 (rf_rd2)
  );

  // Register file model: write at the edge, read data registered.
  logic [DW-1:0] mem [2**RW];
  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int k = 0; k < 2**RW; k++) mem[k] <= '0;
      rf_rd1 <= '0;
      rf_rd2 <= '0;
    end else begin
      if (rf_we) mem[rf_wa] <= rf_wd;
      rf_rd1 <= mem[rf_ra1];
      rf_rd2 <= mem[rf_ra2];
    end
  end

  typedef struct {
    logic          id;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
  } rsp_t;

  rsp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_v(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_q.push_back('{id: id, rd1: a, rd2: b});
  endtask

  // Response monitor.
  always @(negedge clk) begin
    rsp_t e;
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d rd1 0x%0h, required no response",
                 bus.rsp_id, bus.rsp_rd1);
      end else begin
        e = exp_q.pop_front();
        check_v("rsp_id",  64'(bus.rsp_id),  64'(e.id));
        check_v("rsp_rd1", 64'(bus.rsp_rd1), 64'(e.rd1));
        check_v("rsp_rd2", 64'(bus.rsp_rd2), 64'(e.rd2));
      end
    end
  end

  task automatic clr();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_ra1   = '0;
    bus.req_ra2   = '0;
    bus.req_wa    = '0;
    bus.req_wd    = '0;
  endtask

  task automatic rd(input int i, input logic lk, input logic [RW-1:0] a1,
                    input logic [RW-1:0] a2);
    bus.req_valid[i] = 1'b1;
    bus.req_we[i]    = 1'b0;
    bus.req_lock[i]  = lk;
    bus.req_ra1[i]   = a1;
    bus.req_ra2[i]   = a2;
  endtask

  task automatic wr(input int i, input logic lk, input logic [RW-1:0] a,
                    input logic [DW-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_we[i]    = 1'b1;
    bus.req_lock[i]  = lk;
    bus.req_wa[i]    = a;
    bus.req_wd[i]    = d;
  endtask

  task automatic at_neg(input string name, input logic [1:0] rdy, input logic we);
    @(negedge clk);
    check_v({name, "_ready"}, 64'(bus.req_ready), 64'(rdy));
    check_v({name, "_rf_we"}, 64'(rf_we), 64'(we));
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mdl_clr = 1'b1;
    clr();
    next();
    at_neg("reset", 2'b00, 1'b0);
    check_v("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_v("reset_rsp_id",    64'(bus.rsp_id),    64'd0);
    next();
    rst = 1'b0;
    mdl_clr = 1'b0;

    repeat (3) begin
      at_neg("idle", 2'b00, 1'b0);
      check_v("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      next();
    end

    // Write then read the same register back-to-back.
    wr(0, 1'b0, 6'd5, 32'hDEADBEEF);
    at_neg("wr5", 2'b01, 1'b1);
    check_v("wr5_rf_wa", 64'(rf_wa), 64'd5);
    check_v("wr5_rf_wd", 64'(rf_wd), 64'hDEADBEEF);
    next();
    clr(); rd(0, 1'b0, 6'd5, 6'd0);
    push(1'b0, 32'hDEADBEEF, 32'h0);
    at_neg("rd5", 2'b01, 1'b0);
    check_v("rd5_rf_ra1", 64'(rf_ra1), 64'd5);
    next();

    // Preload; alternating single requesters leave the pointer on 0.
    clr(); wr(1, 1'b0, 6'd1, 32'h1111_1111);
    at_neg("wr1", 2'b10, 1'b1); next();
    clr(); wr(0, 1'b0, 6'd2, 32'h2222_2222);
    at_neg("wr2", 2'b01, 1'b1); next();
    clr(); wr(1, 1'b0, 6'd3, 32'h3333_3333);
    at_neg("wr3", 2'b10, 1'b1); next();

    // Both requesters hold reads: grants alternate 0,1,0,1.
    clr(); rd(0, 1'b0, 6'd1, 6'd2); rd(1, 1'b0, 6'd3, 6'd5);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push(1'b0, 32'h1111_1111, 32'h2222_2222);
        at_neg("rr_even", 2'b01, 1'b0);
      end else begin
        push(1'b1, 32'h3333_3333, 32'hDEADBEEF);
        at_neg("rr_odd", 2'b10, 1'b0);
      end
      next();
    end

    // Requester 1 locks, idles two cycles, then releases with a read.
    clr(); wr(1, 1'b1, 6'd6, 32'h0000_0066);
    at_neg("lock_wr", 2'b10, 1'b1); next();
    clr(); rd(0, 1'b0, 6'd1, 6'd2);
    repeat (2) begin
      at_neg("lock_hold", 2'b00, 1'b0);
      next();
    end
    rd(1, 1'b0, 6'd6, 6'd1);
    push(1'b1, 32'h0000_0066, 32'h1111_1111);
    at_neg("lock_rel", 2'b10, 1'b0); next();
    bus.req_valid[1] = 1'b0;
    push(1'b0, 32'h1111_1111, 32'h2222_2222);
    at_neg("after_rel", 2'b01, 1'b0); next();

    // Register 0 behaviour.
    clr(); wr(0, 1'b0, 6'd0, 32'h1234_5678);
    at_neg("r0_wr", 2'b01, !R0Z); next();
    clr(); rd(0, 1'b0, 6'd0, 6'd5);
    push(1'b0, R0Z ? 32'h0 : 32'h1234_5678, 32'hDEADBEEF);
    at_neg("r0_rd", 2'b01, 1'b0); next();

    // Reset while locked by requester 0 with its response on the bus.
    clr(); rd(0, 1'b1, 6'd1, 6'd3);
    push(1'b0, 32'h1111_1111, 32'h3333_3333);
    at_neg("lk_rd", 2'b01, 1'b0); next();
    clr(); rd(1, 1'b0, 6'd2, 6'd2);
    rst = 1'b1;
    at_neg("rst_pulse", 2'b00, 1'b0); next();
    rst = 1'b0;
    push(1'b1, 32'h2222_2222, 32'h2222_2222);
    at_neg("post_rst", 2'b10, 1'b0);
    check_v("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    next();

    clr();
    repeat (3) begin
      at_neg("tail", 2'b00, 1'b0);
      next();
    end
    check_v("pending_responses", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter and sequencer in front of `regfile_32bit`. Serializes read-pair and write requests from two masters onto the single regfile access slot (one read pair or one write per cycle). Provides round-robin fairness, an optional ownership lock for read-modify-write sequences, and a tagged read response one cycle after issue. Sits between the decode/execute path (requester 0) and the load/debug path (requester 1) and the register file.

## Interface
- RWIDTH, 6, register address width; 2**RWIDTH registers
- DWIDTH, 32, data width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  [1:0]  request present, per requester
- req_ready  out  [1:0]  request accepted this cycle (valid && ready = transfer)
- req_we  in  [1:0]  1 = write, 0 = read pair
- req_lock  in  [1:0]  keep ownership after this transfer
- req_ra1, req_ra2  in  [1:0][RWIDTH-1:0]  read addresses
- req_wa  in  [1:0][RWIDTH-1:0]  write address
- req_wd  in  [1:0][DWIDTH-1:0]  write data
- rf_ra1, rf_ra2, rf_wa  out  RWIDTH  to regfile
- rf_wd  out  DWIDTH  to regfile
- rf_we  out  1  to regfile
- rf_rd1, rf_rd2  in  DWIDTH  from regfile (registered read data)
- rsp_valid  out  1  read data valid
- rsp_id  out  1  requester that issued the read
- rsp_rd1, rsp_rd2  out  DWIDTH  read data

## Operation
- Each cycle, at most one requester is granted; grant is combinational from req_valid, state and priority pointer; req_ready = grant.
- Granted request drives rf_* combinationally; rf_we = granted req_we; ungranted cycle: rf_we = 0, addresses/data = 0.
- FSM: IDLE, LOCK0, LOCK1.
  - IDLE: if one valid, grant it; if both, grant the one the pointer names. On a transfer, pointer flips to the other requester.
  - Transfer with req_lock=1 from requester i -> LOCKi.
  - LOCKi: only requester i may be granted; other is held (ready=0). Transfer from i with req_lock=0 -> IDLE, pointer to other requester.
  - LOCKi with req_valid[i]=0: stay in LOCKi, no grant (no timeout; requester must release).
- Read transfer in cycle N: rsp_valid=1 in N+1, rsp_id=i, rsp_rd1/rsp_rd2 = rf_rd1/rf_rd2. No response backpressure; consumer must take it.
- Write transfer: no response; committed at end of the grant cycle.
- Back-to-back write then read of same register: read sees new value (write committed before read capture).

## Timing
- Reset: state IDLE, pointer = requester 0, rsp_valid=0, rsp_id=0; req_ready, rf_we follow IDLE with no requests (0).
- Grant latency 0 cycles; read latency 1 cycle; throughput 1 op/cycle.
- rsp_valid, rsp_id registered; rsp_rd* pass-through of regfile outputs during rsp_valid.
- rst asserted mid-lock or with read in flight: next cycle IDLE, rsp_valid=0, in-flight response dropped.

## Configuration
- REGFILE_ARB_R0_ZERO_EN defined: register 0 is hardwired zero — granted write with wa=0 is accepted (ready=1) but rf_we forced 0; response data for ra=0 is forced to 0 (address registered alongside rsp_valid).
- Undefined: register 0 is an ordinary register.

## Structure
- Package regfile_arb_pkg: state enum (IDLE, LOCK0, LOCK1), requester id typedef, NREQ=2 constant.
- Sub-module regfile_arb_rr2: 2-way round-robin grant with pointer and lock mask input.

## Test plan
- Reset, no requests -> rsp_valid=0, rf_we=0, req_ready=2'b00 for all cycles.
- Req0 write wa=5 wd=0xDEADBEEF, next cycle req0 read ra1=5 ra2=0 -> cycle after read: rsp_valid=1, rsp_id=0, rsp_rd1=0xDEADBEEF, rsp_rd2=0.
- Both valid reads held for 4 cycles -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
- Req1 lock=1 write, then req1 drops valid 2 cycles while req0 valid -> req0 ready=0 throughout; req1 lock=0 read -> req0 granted next cycle.
- With REGFILE_ARB_R0_ZERO_EN: write wa=0 wd=0x12345678 then read ra1=0 -> rf_we=0 on write, rsp_rd1=0; without macro -> rsp_rd1=0x12345678.
- rst pulsed in cycle after read grant while in LOCK0 -> rsp_valid=0 next cycle, state IDLE, req1 grantable immediately.
